mastermind_guess_engine: RTL and testbench

//  Parametrised successor to the Mastermind guess-entry logic: N colour digits entered from switches

---
 rtl/mastermind_guess_engine.sv | 186 ++++++++++++++++++
 tb/tb_mastermind_guess_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_guess_engine.sv
// Mastermind guess engine: switch/pushbutton guess entry plus a sequential black/white peg scorer.
// Build option: define DUP_CHECK_EN to reject guesses that repeat a colour (dup_err instead of a score).
module mastermind_guess_engine #(
  parameter int NUM_DIGITS = 4,
  parameter int COLOR_W    = 3,
  parameter int MAX_TURNS  = 10,
  localparam int CUR_W  = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1),
  localparam int TURN_W = $clog2(MAX_TURNS + 1)
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          key_next_n,
  input  logic                          key_submit_n,
  input  logic [COLOR_W-1:0]            sw_value,
  input  logic [NUM_DIGITS*COLOR_W-1:0] secret,
  output logic [NUM_DIGITS*COLOR_W-1:0] guess,
  output logic [CUR_W-1:0]              cursor,
  output logic                          busy,
  output logic                          score_valid,
  output logic [CNT_W-1:0]              black,
  output logic [CNT_W-1:0]              white,
  output logic [TURN_W-1:0]             turn,
  output logic                          win,
  output logic                          game_over,
  output logic                          dup_err
);

  localparam int NCOL = 1 << COLOR_W;

  typedef enum logic [1:0] {IDLE, SCAN, TALLY, DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]         next_sh, sub_sh;
  logic               next_press, sub_press, accept, submit_go, next_go;
  logic [COLOR_W-1:0] gd [NUM_DIGITS];
  logic [COLOR_W-1:0] sd [NUM_DIGITS];
  logic [CNT_W-1:0]   hist_g [NCOL];
  logic [CNT_W-1:0]   hist_s [NCOL];
  logic [CUR_W-1:0]   k_q;
  logic [COLOR_W-1:0] c_q;
  logic [COLOR_W-1:0] g_k, s_k;
  logic [CNT_W-1:0]   black_acc, match_q, match_total;
  logic [TURN_W-1:0]  turn_inc;
  logic               last_scan, last_tally, dup_q;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Key synchronisers: [0],[1] two-flop sync, [2] delay; released state is all ones
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      next_sh <= 3'b111;
      sub_sh  <= 3'b111;
    end else begin
      next_sh <= {next_sh[1:0], key_next_n};
      sub_sh  <= {sub_sh[1:0], key_submit_n};
    end
  end

  assign next_press  = next_sh[2] & ~next_sh[1];
  assign sub_press   = sub_sh[2] & ~sub_sh[1];
  assign accept      = (state_q == IDLE) && !game_over;
  assign submit_go   = accept && sub_press;
  assign next_go     = accept && next_press && !sub_press;
  assign g_k         = gd[k_q];
  assign s_k         = sd[k_q];
  assign last_scan   = (k_q == CUR_W'(NUM_DIGITS - 1));
  assign last_tally  = (state_q == TALLY) && (c_q == '1);
  assign match_total = match_q + min_cnt(hist_g[c_q], hist_s[c_q]);
  assign turn_inc    = turn + TURN_W'(1);
  assign busy        = (state_q != IDLE);

  // Pack the digit registers onto the guess bus, digit 0 in the low bits
  always_comb begin
    guess = '0;
    for (int i = 0; i < NUM_DIGITS; i++) guess[i*COLOR_W +: COLOR_W] = gd[i];
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> SCAN (N cycles) -> TALLY (2**COLOR_W cycles) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (submit_go) state_d = SCAN;
      SCAN:    if (last_scan) state_d = TALLY;
      TALLY:   if (c_q == '1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Secret snapshot taken on submit; pure data, no reset needed
  always_ff @(posedge CLOCK_50) begin
    if (submit_go)
      for (int i = 0; i < NUM_DIGITS; i++) sd[i] <= secret[i*COLOR_W +: COLOR_W];
  end

  // Guess entry, scan/tally accumulation and registered score outputs
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) gd[i] <= '0;
      for (int c = 0; c < NCOL; c++) begin
        hist_g[c] <= '0;
        hist_s[c] <= '0;
      end
      cursor      <= '0;
      k_q         <= '0;
      c_q         <= '0;
      black_acc   <= '0;
      match_q     <= '0;
      score_valid <= 1'b0;
      black       <= '0;
      white       <= '0;
      turn        <= '0;
      win         <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) gd[cursor] <= sw_value;
          if (submit_go) begin
            k_q       <= '0;
            black_acc <= '0;
          end else if (next_go) begin
            cursor <= (cursor == CUR_W'(NUM_DIGITS - 1)) ? '0 : cursor + CUR_W'(1);
          end
        end
        SCAN: begin
          black_acc   <= black_acc + CNT_W'(g_k == s_k);
          hist_g[g_k] <= hist_g[g_k] + CNT_W'(1);
          hist_s[s_k] <= hist_s[s_k] + CNT_W'(1);
          k_q         <= k_q + CUR_W'(1);
          c_q         <= '0;
          match_q     <= '0;
        end
        TALLY: begin
          match_q <= match_total;
          c_q     <= c_q + COLOR_W'(1);
          if (last_tally && !dup_q) begin
            black       <= black_acc;
            white       <= match_total - black_acc;
            score_valid <= 1'b1;
            turn        <= turn_inc;
            win         <= (black_acc == CNT_W'(NUM_DIGITS));
            game_over   <= (black_acc == CNT_W'(NUM_DIGITS)) || (turn_inc == TURN_W'(MAX_TURNS));
          end
        end
        DONE: begin
          cursor <= '0;
          for (int c = 0; c < NCOL; c++) begin
            hist_g[c] <= '0;
            hist_s[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUP_CHECK_EN
  // Flag a guess colour seen earlier in the scan; report it in place of a score
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      dup_q   <= 1'b0;
      dup_err <= 1'b0;
    end else begin
      dup_err <= 1'b0;
      if (submit_go) dup_q <= 1'b0;
      else if ((state_q == SCAN) && (hist_g[g_k] != '0)) dup_q <= 1'b1;
      if (last_tally && dup_q) dup_err <= 1'b1;
    end
  end
`else
  assign dup_q   = 1'b0;
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_mastermind_guess_engine.sv
// Self-checking bench for mastermind_guess_engine: directed scenarios plus randomized games
// compared against a colour-count scoring model. Honours DUP_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_mastermind_guess_engine;

  localparam int N      = 4;
  localparam int CW     = 3;
  localparam int MAXT   = 10;
  localparam int NCOL   = 1 << CW;
  localparam int CUR_W  = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int TURN_W = $clog2(MAXT + 1);
  localparam int LAT    = 3 + N + NCOL;  // edges from key going low to score_valid visible

  logic              clk = 1'b0;
  logic              RESET = 1'b1;
  logic              key_next_n = 1'b1;
  logic              key_submit_n = 1'b1;
  logic [CW-1:0]     sw_value = '0;
  logic [N*CW-1:0]   secret = '0;
  logic [N*CW-1:0]   guess;
  logic [CUR_W-1:0]  cursor;
  logic              busy, score_valid, win, game_over, dup_err;
  logic [CNT_W-1:0]  black, white;
  logic [TURN_W-1:0] turn;

  mastermind_guess_engine #(.NUM_DIGITS(N), .COLOR_W(CW), .MAX_TURNS(MAXT)) dut (
    .CLOCK_50(clk), .RESET(RESET), .key_next_n(key_next_n), .key_submit_n(key_submit_n),
    .sw_value(sw_value), .secret(secret), .guess(guess), .cursor(cursor), .busy(busy),
    .score_valid(score_valid), .black(black), .white(white), .turn(turn), .win(win),
    .game_over(game_over), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int exp_g [N];
  int gin [N];
  int sin [N];
  int exp_cur, exp_black, exp_white, exp_turn;
  bit exp_win, exp_go, chk_en;
  int vec = 0;
  int err = 0;

  task automatic check(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack_g();
    int p = 0;
    for (int i = N - 1; i >= 0; i--) p = (p << CW) | exp_g[i];
    return p;
  endfunction

  // Mastermind scoring from colour counts: matches = sum of per-colour minima
  function automatic void score_model(input int g[N], input int s[N], output int b, output int w, output bit dup);
    int cg [NCOL];
    int cs [NCOL];
    int m;
    for (int c = 0; c < NCOL; c++) begin cg[c] = 0; cs[c] = 0; end
    b = 0; m = 0; dup = 0;
    for (int k = 0; k < N; k++) begin
      if (g[k] == s[k]) b++;
      cg[g[k]]++;
      cs[s[k]]++;
    end
    for (int c = 0; c < NCOL; c++) begin
      m += (cg[c] < cs[c]) ? cg[c] : cs[c];
      if (cg[c] > 1) dup = 1;
    end
    w = m - b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) exp_g[i] = 0;
    exp_cur = 0; exp_black = 0; exp_white = 0; exp_turn = 0;
    exp_win = 0; exp_go = 0;
  endfunction

  function automatic void rand_digits(output int d[N], input bit distinct);
    for (int i = 0; i < N; i++) begin
      bit ok;
      do begin
        d[i] = int'($urandom_range(NCOL - 1, 0));
        ok = 1;
        if (distinct) for (int j = 0; j < i; j++) if (d[j] == d[i]) ok = 0;
      end while (!ok);
    end
  endfunction

  // Continuous compare while the engine is idle and the model is settled
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("guess", int'(guess), pack_g());
      check("cursor", int'(cursor), exp_cur);
      check("busy_idle", int'(busy), 0);
      check("score_valid_idle", int'(score_valid), 0);
      check("dup_err_idle", int'(dup_err), 0);
      check("black", int'(black), exp_black);
      check("white", int'(white), exp_white);
      check("turn", int'(turn), exp_turn);
      check("win", int'(win), int'(exp_win));
      check("game_over", int'(game_over), int'(exp_go));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_guess"}, int'(guess), 0);
    check({tag, "_cursor"}, int'(cursor), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_valid"}, int'(score_valid), 0);
    check({tag, "_black"}, int'(black), 0);
    check({tag, "_white"}, int'(white), 0);
    check({tag, "_turn"}, int'(turn), 0);
    check({tag, "_win"}, int'(win), 0);
    check({tag, "_over"}, int'(game_over), 0);
    check({tag, "_dup"}, int'(dup_err), 0);
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk); RESET = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst");
    @(negedge clk); RESET = 1'b0;
    model_reset();
    exp_g[0] = int'(sw_value);
    repeat (2) @(posedge clk);
    @(negedge clk); chk_en = 1;
  endtask

  task automatic set_secret();
    for (int k = 0; k < N; k++) secret[k*CW +: CW] = CW'(sin[k]);
  endtask

  task automatic set_sw(input int v);
    chk_en = 0;
    @(negedge clk); sw_value = CW'(v);
    repeat (2) @(posedge clk);
    if (!exp_go) exp_g[exp_cur] = v;
    @(negedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic press_next();
    chk_en = 0;
    @(negedge clk); key_next_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); key_next_n = 1'b1;
    repeat (4) @(posedge clk);
    if (!exp_go) begin
      exp_cur = (exp_cur + 1) % N;
      exp_g[exp_cur] = int'(sw_value);
    end
    @(negedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic enter_guess();
    for (int i = 0; i < N; i++) begin
      set_sw(gin[i]);
      if (i < N - 1) press_next();
    end
  endtask

  task automatic submit();
    int n, eb, ew;
    int s [N];
    bit ed, seen, was_go;
    for (int k = 0; k < N; k++) s[k] = int'(secret[k*CW +: CW]);
    score_model(exp_g, s, eb, ew, ed);
`ifndef DUP_CHECK_EN
    ed = 0;
`endif
    was_go = exp_go;
    chk_en = 0;
    @(negedge clk); key_submit_n = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < LAT + 15) begin
      @(posedge clk); #1; n++;
      if (n == 4) key_submit_n = 1'b1;
      if (score_valid || dup_err) seen = 1;
    end
    key_submit_n = 1'b1;
    if (was_go) begin
      check("ignored_submit", int'(seen), 0);
    end else begin
      check("latency", n, LAT);
      check("busy_done", int'(busy), 1);
      check("pulse_valid", int'(score_valid), ed ? 0 : 1);
      check("pulse_dup", int'(dup_err), ed ? 1 : 0);
      if (!ed) begin
        exp_black = eb; exp_white = ew; exp_turn++;
        exp_win = (eb == N);
        exp_go  = exp_win || (exp_turn == MAXT);
      end
      exp_cur = 0;
      check("score_black", int'(black), exp_black);
      check("score_white", int'(white), exp_white);
      check("score_turn", int'(turn), exp_turn);
      check("score_win", int'(win), int'(exp_win));
      check("score_over", int'(game_over), int'(exp_go));
    end
    @(posedge clk); #1;
    check("pulse_one_cycle", int'(score_valid) + int'(dup_err), 0);
    repeat (2) @(posedge clk);
    if (!exp_go) exp_g[exp_cur] = int'(sw_value);
    @(negedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic abort_scan();
    int seen;
    chk_en = 0;
    @(negedge clk); key_submit_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 key_submit_n = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_scan", int'(busy), 1);
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    check_reset_vals("abort");
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (score_valid || busy) seen = 1;
    end
    check("abort_no_pulse", seen, 0);
    model_reset();
    exp_g[0] = int'(sw_value);
    @(negedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic post_game();
    set_sw(int'($urandom_range(NCOL - 1, 0)));
    press_next();
    submit();
    check("frozen_game_over", int'(game_over), 1);
  endtask

  initial begin
    int b, w;
    bit d;
    chk_en = 0;
    do_reset();

    // Model pins against hand-scored cases
    gin = '{1, 3, 2, 5}; sin = '{1, 2, 3, 4};
    score_model(gin, sin, b, w, d);
    check("pin_a_black", b, 1); check("pin_a_white", w, 2); check("pin_a_dup", int'(d), 0);
    gin = '{1, 1, 2, 2}; sin = '{1, 2, 1, 3};
    score_model(gin, sin, b, w, d);
    check("pin_b_black", b, 1); check("pin_b_white", w, 2); check("pin_b_dup", int'(d), 1);

    // Guess entry and cursor wrap
    gin = '{5, 3, 6, 2};
    enter_guess();
    check("entry_pack", int'(guess), int'(12'b010_110_011_101));
    check("entry_cursor", int'(cursor), 3);
    press_next();
    check("cursor_wrap", int'(cursor), 0);

    // Basic scoring
    sin = '{1, 2, 3, 4}; set_secret();
    gin = '{1, 3, 2, 5}; enter_guess();
    submit();
    check("t3_black", int'(black), 1);
    check("t3_white", int'(white), 2);
    check("t3_turn", int'(turn), 1);

    // Reset while scanning
    rand_digits(gin, 0); enter_guess();
    abort_scan();

    // Duplicate colours
    sin = '{1, 2, 1, 3}; set_secret();
    gin = '{1, 1, 2, 2}; enter_guess();
    submit();
`ifdef DUP_CHECK_EN
    check("dup_turn_held", int'(turn), 0);
`else
    check("dup_black", int'(black), 1);
    check("dup_white", int'(white), 2);
    check("dup_turn", int'(turn), 1);
`endif

    // Randomized game until the turn budget runs out
    for (int it = 0; it < 40 && !exp_go; it++) begin
      rand_digits(sin, 0); set_secret();
      rand_digits(gin, $urandom_range(3, 0) != 0); enter_guess();
      submit();
    end
`ifndef DUP_CHECK_EN
    check("turns_game_over", int'(game_over), 1);
    if (!exp_win) check("turns_at_max", int'(turn), MAXT);
`endif
    post_game();

    // Winning guess
    do_reset();
    rand_digits(sin, 1); set_secret();
    gin = sin; enter_guess();
    submit();
    check("win_flag", int'(win), 1);
    check("win_black", int'(black), N);
    check("win_white", int'(white), 0);
    post_game();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
